// File: rtl/argmax_pkg.sv
// Shared types and defaults for the score_argmax decision stage.
// SCORE_W_DEF matches the MAC output width and is shared with the MAC and its controller.
package argmax_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    localparam int unsigned SCORE_W_DEF = 16;

endpackage

// File: rtl/argmax_cmp.sv
// Combinational compare/select: folds one incoming score into the running best pair.
// Strictly-greater compare, so on a tie the earlier (lower) index is kept.
module argmax_cmp
    import argmax_pkg::*;
#(
    parameter int unsigned SCORE_W = SCORE_W_DEF,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [SCORE_W-1:0] best_score,
    input  logic [IDX_W-1:0]   best_idx,
    input  logic [SCORE_W-1:0] score_data,
    input  logic [IDX_W-1:0]   count,
    input  logic               first,
    output logic [SCORE_W-1:0] nxt_score,
    output logic [IDX_W-1:0]   nxt_idx
);

    always_comb begin
        nxt_score = best_score;
        nxt_idx   = best_idx;
        // The first score of a vector always loads, even a score of 0.
        if (first || (score_data > best_score)) begin
            nxt_score = score_data;
            nxt_idx   = count;
        end
    end

endmodule

// File: rtl/score_argmax.sv
// Collects NUM_CLASSES scores, one per class, and presents the winning class
// index and score behind a valid/ready handshake.
module score_argmax
    import argmax_pkg::*;
#(
    parameter  int unsigned SCORE_W     = SCORE_W_DEF,
    parameter  int unsigned NUM_CLASSES = 4,
    localparam int unsigned IDX_W       = $clog2(NUM_CLASSES)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               score_valid,
    output logic               score_ready,
    input  logic [SCORE_W-1:0] score_data,
    output logic               class_valid,
    input  logic               class_ready,
    output logic [IDX_W-1:0]   class_idx,
    output logic [SCORE_W-1:0] class_score
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    state_t             state;
    state_t             state_nx;
    logic [IDX_W-1:0]   count;
    logic [SCORE_W-1:0] best_score;
    logic [IDX_W-1:0]   best_idx;
    logic [SCORE_W-1:0] nxt_score;
    logic [IDX_W-1:0]   nxt_idx;
    logic               accept;
    logic               last;

    // Ready depends on registered state only; no path from class_ready.
    assign score_ready = (state == COLLECT);
    assign accept      = score_valid && score_ready && !flush;
    assign last        = (count == LAST_IDX);

    argmax_cmp #(
        .SCORE_W (SCORE_W),
        .IDX_W   (IDX_W)
    ) u_cmp (
        .best_score (best_score),
        .best_idx   (best_idx),
        .score_data (score_data),
        .count      (count),
        .first      (count == '0),
        .nxt_score  (nxt_score),
        .nxt_idx    (nxt_idx)
    );

    always_comb begin
        state_nx = state;
        case (state)
            COLLECT: if (accept && last)          state_nx = HOLD;
            HOLD:    if (flush || class_ready)    state_nx = COLLECT;
            default:                              state_nx = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= COLLECT;
            count       <= '0;
            best_score  <= '0;
            best_idx    <= '0;
            class_valid <= 1'b0;
            class_idx   <= '0;
            class_score <= '0;
        end else begin
            state <= state_nx;
            case (state)
                COLLECT: begin
                    if (flush) begin
                        count      <= '0;
                        best_score <= '0;
                        best_idx   <= '0;
                    end else if (accept) begin
                        best_score <= nxt_score;
                        best_idx   <= nxt_idx;
                        if (last) begin
                            count       <= '0;
                            class_valid <= 1'b1;
                            class_idx   <= nxt_idx;
                            class_score <= nxt_score;
                        end else begin
                            count <= count + IDX_W'(1);
                        end
                    end
                end
                HOLD: begin
                    // flush drops the pending decision; otherwise wait for the handshake.
                    if (flush || class_ready) class_valid <= 1'b0;
                end
                default: class_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_score_argmax.sv
// Scoreboard bench for score_argmax: directed cases plus randomized gapped
// vectors checked against a max/lowest-index reference model.
module tb_score_argmax;

    localparam int N = 4;

    typedef struct {
        int idx;
        int score;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        score_valid;
    logic        score_ready;
    logic [15:0] score_data;
    logic        class_valid;
    logic        class_ready;
    logic [1:0]  class_idx;
    logic [15:0] class_score;

    int   total;
    int   bad;
    int   hs_cnt;
    int   last_waits;
    bit   rand_rdy;
    exp_t expq[$];
    exp_t mon_e;

    logic        prev_hold;
    logic [15:0] prev_data;

    score_argmax #(
        .SCORE_W     (16),
        .NUM_CLASSES (N)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .score_valid (score_valid),
        .score_ready (score_ready),
        .score_data  (score_data),
        .class_valid (class_valid),
        .class_ready (class_ready),
        .class_idx   (class_idx),
        .class_score (class_score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t ref_model(input int unsigned s[N]);
        exp_t r;
        int   bi;
        bi = 0;
        for (int i = 1; i < N; i++)
            if (s[i] > s[bi]) bi = i;
        r.idx   = bi;
        r.score = int'(s[bi]);
        return r;
    endfunction

    task automatic push_exp(input int idx, input int score);
        exp_t e;
        e.idx   = idx;
        e.score = score;
        expq.push_back(e);
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Holds score_valid with stable data until the DUT accepts it (bounded).
    task automatic send(input int unsigned d);
        logic rdy;
        last_waits  = 0;
        score_valid = 1'b1;
        score_data  = 16'(d);
        forever begin
            @(negedge clk);
            rdy = score_ready;
            @(posedge clk);
            #1;
            last_waits++;
            if (rand_rdy) class_ready = 1'($urandom_range(0, 1));
            if (rdy) break;
            if (last_waits > 200) begin
                total++;
                bad++;
                $display("FAIL send_timeout: got=no_accept expected=accept data=%0d", d);
                break;
            end
        end
        score_valid = 1'b0;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            score_data = 16'($urandom);
            @(posedge clk);
            #1;
            if (rand_rdy) class_ready = 1'($urandom_range(0, 1));
        end
    endtask

    // Monitor: pops the scoreboard on every completed output handshake.
    always @(negedge clk) begin
        if (rst_n && class_valid && class_ready && !flush) begin
            hs_cnt++;
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_decision: got idx=%0d score=%0d expected=none",
                         class_idx, class_score);
            end else begin
                mon_e = expq.pop_front();
                check("class_idx", int'(class_idx), mon_e.idx);
                check("class_score", int'(class_score), mon_e.score);
            end
        end
    end

    // Producer rule: data stable while valid and not ready.
    always @(negedge clk) begin
        if (rst_n && prev_hold && score_valid) check("producer_stable", int'(score_data), int'(prev_data));
        prev_hold = score_valid && !score_ready;
        prev_data = score_data;
    end

    initial begin
        int unsigned s[N];
        int          hs_before;

        total = 0; bad = 0; hs_cnt = 0; rand_rdy = 1'b0;
        prev_hold = 1'b0; prev_data = '0;
        rst_n = 1'b0; flush = 1'b0; score_valid = 1'b0; score_data = '0; class_ready = 1'b0;

        #12;
        check("rst_class_valid", int'(class_valid), 0);
        check("rst_class_idx", int'(class_idx), 0);
        check("rst_class_score", int'(class_score), 0);
        #10 rst_n = 1'b1;
        #1;
        check("rst_score_ready", int'(score_ready), 1);
        @(posedge clk); #1;

        // Basic: latency 1 and a single-cycle ready bubble.
        class_ready = 1'b1;
        push_exp(1, 300);
        send(100); send(300); send(200); send(50);
        check("basic_valid_latency", int'(class_valid), 1);
        check("basic_ready_low", int'(score_ready), 0);
        @(posedge clk); #1;
        check("basic_ready_back", int'(score_ready), 1);
        check("basic_valid_clear", int'(class_valid), 0);

        // Ties and first-zero.
        push_exp(0, 0);
        send(0); send(0); send(0); send(0);
        push_exp(1, 700);
        send(500); send(700); send(700); send(10);

        // Backpressure: decision holds while a 5th score waits.
        idle(2);
        class_ready = 1'b0;
        push_exp(3, 65535);
        send(1); send(2); send(3); send(65535);
        push_exp(3, 10);
        score_valid = 1'b1;
        score_data  = 16'd7;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", int'(class_valid), 1);
            check("bp_idx", int'(class_idx), 3);
            check("bp_score", int'(class_score), 65535);
            check("bp_ready", int'(score_ready), 0);
            @(posedge clk); #1;
        end
        class_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_after_hs_ready", int'(score_ready), 1);
        check("bp_after_hs_valid", int'(class_valid), 0);
        send(7);
        check("bp_accept_wait", last_waits, 1);
        send(8); send(9); send(10);

        // Flush mid-vector discards earlier scores and the concurrent one.
        idle(2);
        push_exp(3, 40);
        send(900); send(800);
        flush = 1'b1; score_valid = 1'b1; score_data = 16'd999;
        @(posedge clk); #1;
        flush = 1'b0; score_valid = 1'b0;
        send(10); send(20); send(30); send(40);

        // Flush in HOLD beats a concurrent class_ready.
        idle(2);
        class_ready = 1'b0;
        send(5); send(6); send(7); send(8);
        hs_before   = hs_cnt;
        flush       = 1'b1;
        class_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("hold_flush_valid", int'(class_valid), 0);
        check("hold_flush_ready", int'(score_ready), 1);
        check("hold_flush_no_hs", hs_cnt, hs_before);

        // Async reset mid-vector, released off a clock edge.
        send(1000); send(2000);
        #3 rst_n = 1'b0;
        #1;
        check("arst_valid", int'(class_valid), 0);
        check("arst_idx", int'(class_idx), 0);
        check("arst_score", int'(class_score), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        push_exp(1, 9);
        send(3); send(9); send(1); send(2);

        // Randomized gapped vectors with random output backpressure.
        rand_rdy = 1'b1;
        for (int d = 0; d < 1000; d++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) s[i] = $urandom_range(0, 3);
                else                            s[i] = $urandom_range(0, 65535);
            end
            expq.push_back(ref_model(s));
            for (int i = 0; i < N; i++) begin
                idle(int'($urandom_range(0, 2)));
                send(s[i]);
            end
        end

        rand_rdy    = 1'b0;
        class_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (expq.size() == 0) break;
            @(posedge clk); #1;
        end
        check("drain_pending", expq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
